// File: rtl/morse_word_uart_tx.sv
// morse_word_uart_tx
// Last stage before the board UART pin. Latches a decoded Morse word on the
// rising edge of word_ended, maps each character code to ASCII and sends the
// word as 8N1 bytes, then an optional '*' error marker and a ' ' separator.
// The baud divider is local and independent of the Morse timing enable.

`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef MAX_CHARS
`define MAX_CHARS 8
`endif

module morse_word_uart_tx #(
    parameter int CHAR_W    = `CHAR_W,
    parameter int MAX_CHARS = `MAX_CHARS,
    parameter int CLK_DIV   = 434
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHAR_W*MAX_CHARS-1:0]   word,
    input  logic                          word_ended,
    input  logic                          error,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = $clog2(MAX_CHARS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_CHARS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Which part of the word the next LOAD picks from.
    typedef enum logic [1:0] {
        PH_CHAR = 2'd0,
        PH_SEP  = 2'd1,
        PH_DONE = 2'd2
    } phase_t;

    // Character code to ASCII; code 0 is handled by the caller as end-of-word.
    function automatic logic [7:0] char_to_ascii(input logic [CHAR_W-1:0] code);
        logic [31:0] cv;
        logic [7:0]  res;
        cv = 32'(code);
        if (cv >= 32'd1 && cv <= 32'd26) begin
            res = 8'h40 + 8'(cv);
        end else if (cv >= 32'd27 && cv <= 32'd36) begin
            res = 8'h30 + 8'(cv - 32'd27);
        end else begin
            res = 8'h3F;
        end
        return res;
    endfunction

    state_t                      state_r, state_s;
    phase_t                      phase_r, phase_s;
    logic                        we_prev_r;
    logic [CHAR_W*MAX_CHARS-1:0] word_r, word_s;
    logic                        err_r, err_s;
    logic [SLOT_W-1:0]           slot_r, slot_s;
    logic [7:0]                  byte_r, byte_s;
    logic [2:0]                  bit_idx_r, bit_idx_s;
    logic [CNT_W-1:0]            cnt_r, cnt_s;
    logic                        tx_r, tx_s;
    logic                        busy_r, busy_s;
    logic                        overflow_r, overflow_s;
    logic                        we_rise_s;
    logic                        bit_end_s;
    logic                        char_avail_s;
    logic [CHAR_W-1:0]           code_s;

    assign we_rise_s = word_ended & ~we_prev_r;
    assign bit_end_s = (cnt_r == CNT_MAX);

    // Pick the code at the current slot; out-of-range slots read as 0.
    always_comb begin
        code_s = '0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            code_s = (slot_r == SLOT_W'(i)) ? word_r[i*CHAR_W +: CHAR_W] : code_s;
        end
        char_avail_s = (slot_r < SLOT_LAST) && (code_s != '0);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        word_s     = word_r;
        err_s      = err_r;
        slot_s     = slot_r;
        byte_s     = byte_r;
        bit_idx_s  = bit_idx_r;
        cnt_s      = cnt_r;
        // A word arriving while busy (including the cycle busy drops) is lost.
        overflow_s = overflow_r | (we_rise_s & busy_r);

        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (we_rise_s) begin
                    word_s  = word;
                    err_s   = error;
                    slot_s  = '0;
                    phase_s = PH_CHAR;
                    if ((word[CHAR_W-1:0] != '0) || error) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_s     = '0;
                bit_idx_s = 3'd0;
                state_s   = ST_START;
                if ((phase_r == PH_CHAR) && char_avail_s) begin
                    byte_s = char_to_ascii(code_s);
                    slot_s = slot_r + SLOT_W'(1);
                end else if ((phase_r == PH_CHAR) && err_r) begin
                    byte_s  = 8'h2A;
                    phase_s = PH_SEP;
                end else begin
                    byte_s  = 8'h20;
                    phase_s = PH_DONE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_s = '0;
                    // The separator is the last byte; skip the final LOAD so
                    // busy drops right after its stop bit.
                    if (phase_r == PH_DONE) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase

        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = byte_s[bit_idx_s];
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_prev_r  <= 1'b1;
            phase_r    <= PH_CHAR;
            word_r     <= '0;
            err_r      <= 1'b0;
            slot_r     <= '0;
            byte_r     <= 8'h00;
            bit_idx_r  <= 3'd0;
            cnt_r      <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            we_prev_r  <= word_ended;
            phase_r    <= phase_s;
            word_r     <= word_s;
            err_r      <= err_s;
            slot_r     <= slot_s;
            byte_r     <= byte_s;
            bit_idx_r  <= bit_idx_s;
            cnt_r      <= cnt_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            overflow_r <= overflow_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_morse_word_uart_tx.sv
// Bench for morse_word_uart_tx with CHAR_W=6, MAX_CHARS=4, CLK_DIV=4.
// Expected bytes are queued when a word is driven; a UART receiver process
// decodes tx and compares each received byte against the queue head.

module tb_morse_word_uart_tx;

    localparam int CW  = 6;
    localparam int MC  = 4;
    localparam int DIV = 4;
    localparam int BYTE_CYC = 10 * DIV + 1;

    logic              clk;
    logic              rst_n;
    logic [CW*MC-1:0]  word;
    logic              word_ended;
    logic              error;
    logic              tx;
    logic              busy;
    logic              overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b1;

    morse_word_uart_tx #(
        .CHAR_W   (CW),
        .MAX_CHARS(MC),
        .CLK_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .word      (word),
        .word_ended(word_ended),
        .error     (error),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_ascii(input logic [CW-1:0] c);
        if (c >= 6'd1 && c <= 6'd26) return 8'd64 + {2'b00, c};
        if (c >= 6'd27 && c <= 6'd36) return 8'd48 + ({2'b00, c} - 8'd27);
        return 8'h3F;
    endfunction

    task automatic push_expected(input logic [CW*MC-1:0] w, input logic e, output int k);
        logic [CW-1:0] c;
        k = 0;
        for (int i = 0; i < MC; i++) begin
            c = w[i*CW +: CW];
            if (c == 6'd0) break;
            exp_q.push_back(model_ascii(c));
            k++;
        end
        if (e) begin
            exp_q.push_back(8'h2A);
            k++;
        end
        exp_q.push_back(8'h20);
        k++;
    endtask

    // UART receiver: detects a start bit and checks every sample of every bit.
    initial begin : monitor
        logic [7:0] b;
        logic       frame_ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
                frame_ok = 1'b1;
                b = 8'h00;
                for (int j = 1; j < DIV; j++) begin
                    @(negedge clk);
                    if (tx !== 1'b0) frame_ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < DIV; j++) begin
                        @(negedge clk);
                        if (j == 0) b[i] = tx;
                        else if (tx !== b[i]) frame_ok = 1'b0;
                    end
                end
                for (int j = 0; j < DIV; j++) begin
                    @(negedge clk);
                    if (tx !== 1'b1) frame_ok = 1'b0;
                end
                n_checks++;
                if (frame_ok !== 1'b1) $display("FAIL frame_timing: byte %h frame_ok=%b want 1", b, frame_ok);
                else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rx_byte: got %h, want none (queue empty)", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) $display("FAIL rx_byte: got %h want %h", b, e);
                    else n_pass++;
                end
            end
        end
    end

    // Send one word and measure busy; inject_at>=3 injects a second word_ended
    // rise at that busy-cycle count.
    task automatic run_word(input logic [CW*MC-1:0] w, input logic e, input int inject_at);
        int k;
        int cnt;
        bit done;
        push_expected(w, e, k);
        word_ended = 1'b0;
        word = w;
        error = e;
        repeat (2) @(negedge clk);
        word_ended = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL latency_busy: busy=%b want 1", busy);
        else n_pass++;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL latency_tx_idle: tx=%b want 1", tx);
        else n_pass++;
        cnt = 1;
        done = 1'b0;
        for (int g = 0; g < 5000; g++) begin
            @(negedge clk);
            if (cnt == 1) begin
                n_checks++;
                if (tx !== 1'b0) $display("FAIL start_bit_edge: tx=%b want 0", tx);
                else n_pass++;
            end
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            cnt++;
            if (inject_at >= 3 && cnt == inject_at - 2) begin
                word_ended = 1'b0;
                word = {MC{6'd63}};
                error = 1'b1;
            end
            if (inject_at >= 3 && cnt == inject_at) word_ended = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL busy_timeout: busy still high after %0d cycles", cnt);
        else n_pass++;
        n_checks++;
        if (cnt != k * BYTE_CYC) $display("FAIL busy_length: got %0d want %0d", cnt, k * BYTE_CYC);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bytes_missing: %0d left want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        bit bad_tx;
        bit bad_busy;
        rst_n = 1'b0;
        word_ended = 1'b1;
        word = '0;
        error = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: tx=%b want 1", tx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b want 0", busy);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: overflow=%b want 0", overflow);
        else n_pass++;
        rst_n = 1'b1;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        n_checks++;
        if (bad_tx) $display("FAIL post_reset_tx: tx left idle, want stay 1");
        else n_pass++;
        n_checks++;
        if (bad_busy) $display("FAIL post_reset_busy: busy rose, want stay 0");
        else n_pass++;
    endtask

    task automatic test_hi();
        run_word({6'd0, 6'd0, 6'd9, 6'd8}, 1'b0, 0);
    endtask

    task automatic test_map_error();
        run_word({6'd0, 6'd40, 6'd36, 6'd27}, 1'b1, 0);
    endtask

    task automatic test_full_word();
        run_word({6'd1, 6'd1, 6'd1, 6'd1}, 1'b0, 0);
    endtask

    task automatic test_overflow();
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL overflow_before: overflow=%b want 0", overflow);
        else n_pass++;
        run_word({6'd0, 6'd0, 6'd2, 6'd3}, 1'b0, BYTE_CYC + 20);
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL overflow_set: overflow=%b want 1", overflow);
        else n_pass++;
        repeat (50) @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL overflow_sticky: overflow=%b want 1", overflow);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL overflow_dropped: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_empty_and_reset();
        bit bad;
        bit seen;
        word_ended = 1'b0;
        word = '0;
        error = 1'b0;
        repeat (2) @(negedge clk);
        word_ended = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL empty_word: traffic or busy seen, want none");
        else n_pass++;
        mon_en = 1'b0;
        word_ended = 1'b0;
        word = {6'd0, 6'd0, 6'd0, 6'd8};
        repeat (2) @(negedge clk);
        word_ended = 1'b1;
        seen = 1'b0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL start_bit_seen: no start bit within 10 cycles");
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL async_reset_tx: tx=%b want 1", tx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL async_reset_busy: busy=%b want 0", busy);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL async_reset_overflow: overflow=%b want 0", overflow);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL after_reset_idle: busy=%b tx=%b want 0/1", busy, tx);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_drop_at_busy_fall();
        // "A" then ' ' -> 2 bytes; rise arrives on the last busy cycle.
        run_word({6'd0, 6'd0, 6'd0, 6'd1}, 1'b0, 2 * BYTE_CYC);
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL drop_at_fall_overflow: overflow=%b want 1", overflow);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL drop_at_fall_busy: busy=%b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hi();
        test_map_error();
        test_full_word();
        test_overflow();
        test_empty_and_reset();
        test_drop_at_busy_fall();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
